// File: rtl/sort_frame_packer.sv
// sort_frame_packer: packs a serial valid/ready byte stream into 8-byte frames for the
// 8-entry byte sorter. The packer holds one finished frame in the output registers and
// assembles the next frame at the same time. A frame that in_last closes early is padded
// with PAD_VALUE, so the padding sorts to the tail.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   in_valid/in_ready/in_data/in_last   upstream byte stream
//   out_valid/out_ready                 frame handshake to the sorter
//   a, a1..a7        frame elements 0..7, in arrival order
//   out_count        number of real (non-pad) bytes in the frame, 1..8
//   frames_out       frames handed off, wraps at 16 bits
//
// Optional feature: define SORT_PACK_TIMEOUT_EN to force-flush a partial frame after
// TIMEOUT_CYCLES idle cycles. Without the macro, a partial frame waits for more bytes.
module sort_frame_packer #(
  parameter int unsigned       DATA_W         = 8,
  parameter logic [DATA_W-1:0] PAD_VALUE      = 8'hFF,
  parameter int unsigned       TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] a4,
  output logic [DATA_W-1:0] a5,
  output logic [DATA_W-1:0] a6,
  output logic [DATA_W-1:0] a7,
  output logic [3:0]        out_count,
  output logic [15:0]       frames_out
);

  typedef enum logic [0:0] {StCollect, StPending} state_e;

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] asm_q [8];
  logic [3:0]        pend_count_q;
  logic [DATA_W-1:0] out_q [8];
  logic [3:0]        out_count_q;
  logic              out_valid_q;
  logic [15:0]       frames_q;

  logic              accept;
  logic              close;
  logic              slot_free;
  logic              out_take;
  logic              timeout_hit;
  logic [DATA_W-1:0] frame [8];
  logic [3:0]        frame_count;

  assign in_ready  = (state_q == StCollect);
  assign accept    = in_valid && in_ready;
  assign out_take  = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign close     = (accept && ((idx_q == 3'd7) || in_last)) || timeout_hit;

  // Closing frame as it would look after this edge. The accepted byte (if any) is merged
  // in at idx. Everything above it is padding. This one path serves both the normal close
  // and the timeout close.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < idx_q) begin
        frame[i] = asm_q[i];
      end else if ((3'(i) == idx_q) && accept) begin
        frame[i] = in_data;
      end else begin
        frame[i] = PAD_VALUE;
      end
    end
    frame_count = {1'b0, idx_q} + {3'b000, accept};
  end

`ifdef SORT_PACK_TIMEOUT_EN
  logic [15:0] idle_q;

  assign timeout_hit = (state_q == StCollect) && !accept && (idx_q != 3'd0) &&
                       (idle_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_q <= '0;
    end else if (accept || close || (state_q != StCollect) || (idx_q == 3'd0)) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StCollect;
      idx_q        <= '0;
      pend_count_q <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      frames_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        asm_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      // A frame load later in this block overrides this clear.
      if (out_take) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StCollect: begin
          if (accept && !close) begin
            asm_q[idx_q] <= in_data;
            idx_q        <= idx_q + 3'd1;
          end
          if (close) begin
            idx_q <= '0;
            if (slot_free) begin
              out_q       <= frame;
              out_count_q <= frame_count;
              out_valid_q <= 1'b1;
              frames_q    <= frames_q + 16'd1;
            end else begin
              asm_q        <= frame;
              pend_count_q <= frame_count;
              state_q      <= StPending;
            end
          end
        end
        StPending: begin
          if (out_take) begin
            out_q       <= asm_q;
            out_count_q <= pend_count_q;
            out_valid_q <= 1'b1;
            frames_q    <= frames_q + 16'd1;
            state_q     <= StCollect;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign frames_out = frames_q;
  assign a          = out_q[0];
  assign a1         = out_q[1];
  assign a2         = out_q[2];
  assign a3         = out_q[3];
  assign a4         = out_q[4];
  assign a5         = out_q[5];
  assign a6         = out_q[6];
  assign a7         = out_q[7];

endmodule

// File: tb/tb_sort_frame_packer.sv
// Directed testbench for sort_frame_packer. The bench drives inputs and samples outputs
// 1 time unit after each rising edge. Frame expectations are packed with element 0 in the
// low byte.
module tb_sort_frame_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  a, a1, a2, a3, a4, a5, a6, a7;
  logic [3:0]  out_count;
  logic [15:0] frames_out;
  logic [63:0] got_frame;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign got_frame = {a7, a6, a5, a4, a3, a2, a1, a};

  sort_frame_packer #(
    .DATA_W        (8),
    .PAD_VALUE     (8'hFF),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .a5        (a5),
    .a6        (a6),
    .a7        (a7),
    .out_count (out_count),
    .frames_out(frames_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp, input logic [3:0] cnt);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_a%0d", tag, k), 32'(got_frame[8*k +: 8]), 32'(exp[8*k +: 8]));
    end
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  logic [7:0] full_vals [8];
  int         ready_low;
  int         pulse_cnt;
  int         pulse_pos [2];
  logic [7:0] first_a;

  initial begin
    full_vals = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
    reset     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;

    // Reset state, first cycle after release
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_a7", 32'(a7), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_frames", 32'(frames_out), 32'd0);

    // Full frame
    for (int i = 0; i < 8; i++) begin
      send_byte(full_vals[i], 1'b0);
      if (i == 6) check("full_not_yet", 32'(out_valid), 32'd0);
    end
    idle_inputs();
    check_frame("full", 64'h0408020701090305, 4'd8);
    check("full_frames", 32'(frames_out), 32'd1);
    tick();
    check("full_pulse_end", 32'(out_valid), 32'd0);

    // Short frame, padded
    send_byte(8'd10, 1'b0);
    send_byte(8'd20, 1'b0);
    send_byte(8'd30, 1'b1);
    idle_inputs();
    check_frame("short", 64'hFFFFFFFFFF1E140A, 4'd3);
    check("short_frames", 32'(frames_out), 32'd2);
    tick();
    check("short_pulse_end", 32'(out_valid), 32'd0);

    // Backpressure: second frame goes pending
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send_byte(8'(i), 1'b0);
      if (i == 8) check_frame("bp_first", 64'h0807060504030201, 4'd8);
    end
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check_frame("bp_hold", 64'h0807060504030201, 4'd8);
    check("bp_frames_hold", 32'(frames_out), 32'd3);
    // Bytes offered while pending must be ignored
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    tick();
    idle_inputs();
    check("bp_still_pending", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_frame("bp_second", 64'h100F0E0D0C0B0A09, 4'd8);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_frames", 32'(frames_out), 32'd4);
    out_ready = 1'b1;
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Back-to-back full frames with no gaps
    ready_low = 0;
    pulse_cnt = 0;
    pulse_pos = '{-1, -1};
    first_a   = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (!in_ready) ready_low++;
      send_byte(8'(8'h21 + i), 1'b0);
      if (out_valid) begin
        if (pulse_cnt < 2) pulse_pos[pulse_cnt] = i;
        if (pulse_cnt == 0) first_a = a;
        pulse_cnt++;
      end
    end
    idle_inputs();
    check("b2b_ready_low", 32'(ready_low), 32'd0);
    check("b2b_pulses", 32'(pulse_cnt), 32'd2);
    check("b2b_pulse0", 32'(pulse_pos[0]), 32'd7);
    check("b2b_pulse1", 32'(pulse_pos[1]), 32'd15);
    check("b2b_first_a", 32'(first_a), 32'h21);
    check_frame("b2b_second", 64'h302F2E2D2C2B2A29, 4'd8);
    check("b2b_frames", 32'(frames_out), 32'd6);

    // Single-byte frames on consecutive edges keep out_valid high
    send_byte(8'h51, 1'b1);
    check_frame("one_a", 64'hFFFFFFFFFFFFFF51, 4'd1);
    send_byte(8'h52, 1'b1);
    idle_inputs();
    check_frame("one_b", 64'hFFFFFFFFFFFFFF52, 4'd1);
    check("one_frames", 32'(frames_out), 32'd8);
    tick();
    check("one_end", 32'(out_valid), 32'd0);

    // Reset mid-frame discards the partial bytes
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b0);
    send_byte(8'h97, 1'b0);
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_frames", 32'(frames_out), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 1'b0);
    idle_inputs();
    check_frame("mid_rst", 64'h1817161514131211, 4'd8);
    check("mid_rst_frames1", 32'(frames_out), 32'd1);
    tick();
    check("mid_rst_end", 32'(out_valid), 32'd0);

`ifdef SORT_PACK_TIMEOUT_EN
    // Partial frame is flushed after 4 idle cycles
    send_byte(8'h42, 1'b0);
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    check("to_not_yet", 32'(out_valid), 32'd0);
    tick();
    check_frame("to_flush", 64'hFFFFFFFFFFFFFF42, 4'd1);
    check("to_frames", 32'(frames_out), 32'd2);
`else
    // Partial frame waits indefinitely for more bytes
    send_byte(8'h42, 1'b0);
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    check("wait_no_flush", 32'(out_valid), 32'd0);
    send_byte(8'h43, 1'b1);
    idle_inputs();
    check_frame("wait_close", 64'hFFFFFFFFFFFF4342, 4'd2);
    check("wait_frames", 32'(frames_out), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_frame_packer.md
Name: sort_frame_packer

Overview:
Upstream stage of the 8-entry byte sorter: collects a serial byte stream (valid/ready) into 8-byte frames and presents each frame in parallel, with a valid, on the sorter input fields a, a1..a7.
Short frames closed early by in_last are padded so padding sorts to the tail in ascending order.
Holds one assembled frame in the output register plus one frame in assembly, so the input keeps flowing while the output waits.

Parameters:
DATA_W, 8, width of each element; must match the sorter (8).
PAD_VALUE, 8'hFF, fill value for unused slots of a short frame.
TIMEOUT_CYCLES, 64, idle cycles before a partial frame is force-flushed (used only with the optional feature); legal range 1..65535.

Ports:
clock  in  1  single clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
in_valid  in  1  input byte valid.
in_ready  out  1  packer can accept a byte this cycle.
in_data  in  DATA_W  input byte.
in_last  in  1  byte is the last of its frame; closes the frame early.
out_valid  out  1  a..a7 hold a complete frame.
out_ready  in  1  consumer takes the frame; tie to 1 for the sorter, which samples valid every cycle.
a, a1, a2, a3, a4, a5, a6, a7  out  DATA_W each  frame elements 0..7, in arrival order.
out_count  out  4  real (non-pad) bytes in the frame, 1..8.
frames_out  out  16  count of frames handed off; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (reset==0 at an edge):
  - out_valid=0; a..a7=0; out_count=0; frames_out=0.
  - Write index idx=0; assembly buffer cleared; state COLLECT.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-frame discards the partial frame and any held output frame.
- Accept: a byte is accepted when in_valid && in_ready at a clock edge. It is written to assembly slot idx, then idx increments.
- Frame close: a frame closes when the accepted byte has idx==7 or in_last==1.
  - in_last on the 8th byte is an ordinary full frame.
  - A frame of 0 bytes cannot occur.
- States:
  - COLLECT: in_ready=1. On frame close:
    - If the output slot is free (out_valid==0, or out_valid && out_ready in this same cycle), the frame moves to the output registers at that edge.
    - Otherwise go to PENDING.
  - PENDING: in_ready=0; assembled frame held. When out_valid && out_ready, the held frame moves to the output at that edge, then return to COLLECT with idx=0.
- Transfer to output:
  - Slots idx..7 (positions >= count) are loaded with PAD_VALUE.
  - out_count = number of real bytes.
  - out_valid=1 from the next cycle.
  - frames_out increments on each transfer.
  - idx resets to 0, so the next byte may be accepted in the same cycle the frame closes (no bubble when the output is free).
- Latency: closing byte accepted at edge T -> out_valid=1 and data visible after edge T (cycle T+1), provided the slot is free.
- Output hold: a..a7, out_count and out_valid stay stable while out_valid && !out_ready. With out_ready tied to 1, out_valid is a one-cycle pulse per frame.
- Simultaneous output handshake and frame close: the output frame leaves and the new frame loads at the same edge, so out_valid stays 1 for back-to-back frames.
- in_data and in_last are ignored when the byte is not accepted.

Optional Feature:
SORT_PACK_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter resets on every accepted byte and counts while idx>0 in COLLECT with no byte accepted.
  - On reaching TIMEOUT_CYCLES, the partial frame closes exactly as if the last accepted byte had carried in_last: padded, out_count=idx, same PENDING rules apply.
  - The counter is cleared by reset and on close.
- Undefined: no counter is built; a partial frame waits indefinitely for more bytes or in_last.

Test Plan:
- Full frame: release reset, send bytes 5,3,9,1,7,2,8,4 on consecutive cycles, out_ready=1 -> one cycle after the 8th byte: a..a7=5,3,9,1,7,2,8,4; out_count=8; out_valid pulse of 1 cycle; frames_out=1.
- Short frame: send 10,20,30 with in_last on 30 -> a,a1,a2=10,20,30; a3..a7=8'hFF; out_count=3.
- Backpressure: out_ready=0, send two full frames (1..8 then 9..16) -> first frame held stable; in_ready drops after byte 16. Raise out_ready for 1 cycle -> frame 9..16 appears next cycle; in_ready returns to 1.
- Back-to-back: stream 16 bytes with no gaps, out_ready=1 -> in_ready never drops; out_valid pulses exactly 8 cycles apart; frames_out=2.
- Reset mid-frame: send 3 bytes, pull reset low 1 cycle, then send 8 bytes 0x11..0x18 -> output frame is 0x11..0x18 with no leftover bytes; frames_out=1.
- With SORT_PACK_TIMEOUT_EN, TIMEOUT_CYCLES=4: send 0x42 then idle -> 4 idle cycles later the frame closes; a=0x42, a1..a7=8'hFF, out_count=1.
